// File: rtl/ccc_pll_lock_sequencer.sv
// Power-up/lock sequencer for the PF_CCC PLL: holds the PLL in power-down, qualifies a
// synchronized lock with timeout/stability/retry rules, then releases a delayed fabric reset.
module ccc_pll_lock_sequencer #(
  parameter int unsigned PWRDN_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned RST_DELAY    = 16,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       restart_i,
  input  logic       pll_lock_i,
  output logic       pll_powerdown_n_o,
  output logic       fab_reset_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_A = (PWRDN_CYCLES > LOCK_TIMEOUT) ? PWRDN_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B = (LOCK_STABLE > RST_DELAY) ? LOCK_STABLE : RST_DELAY;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PWRDN_LAST   = CW'(PWRDN_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] RSTDLY_LAST  = CW'(RST_DELAY - 1);
  localparam logic [3:0]    MAX_R        = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWRDN   = 3'd1,
    S_WAIT    = 3'd2,
    S_STABLE  = 3'd3,
    S_RST_DLY = 3'd4,
    S_RUN     = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          lock_lost_q, lock_lost_d;
  logic          sync1_q, lock_s_q;
  logic          pwrdn_n_q, fab_rst_n_q, ready_q, fail_q;
  logic          reenter;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    cnt_d       = cnt_q + 1'b1;
    reenter     = 1'b0;

    if (!enable_i) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else if (restart_i && (state_q != S_IDLE)) begin
      // Restart from PWRDN counts as a fresh entry even if already there.
      state_d     = S_PWRDN;
      retry_d     = '0;
      lock_lost_d = 1'b0;
      reenter     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_PWRDN;
        S_PWRDN:  if (cnt_q == PWRDN_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == MAX_R) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_PWRDN;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q)                  state_d = S_WAIT;
          else if (cnt_q == STABLE_LAST)  state_d = S_RST_DLY;
        end
        S_RST_DLY: begin
          if (!lock_s_q) begin
            lock_lost_d = 1'b1;
            state_d     = S_PWRDN;
          end else if (cnt_q == RSTDLY_LAST) begin
            retry_d = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            lock_lost_d = 1'b1;
            state_d     = S_PWRDN;
          end
        end
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_IDLE;
      endcase
    end

    if ((state_d != state_q) || reenter ||
        (state_d inside {S_IDLE, S_RUN, S_FAIL})) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pwrdn_n_q   <= 1'b0;
      fab_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= pll_lock_i;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      // Outputs decoded from the next state so they change on the entering edge.
      pwrdn_n_q   <= (state_d inside {S_WAIT, S_STABLE, S_RST_DLY, S_RUN});
      fab_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_powerdown_n_o = pwrdn_n_q;
  assign fab_reset_n_o     = fab_rst_n_q;
  assign ready_o           = ready_q;
  assign fail_o            = fail_q;
  assign lock_lost_o       = lock_lost_q;
  assign retry_cnt_o       = retry_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_ccc_pll_lock_sequencer.sv
// Directed bench for ccc_pll_lock_sequencer with default parameters; expected values
// are hand-computed cycle positions relative to the clock edges stepped below.
module tb_ccc_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst, enable, restart, pll_lock;
  logic       pwrdn_n, fab_rst_n, ready, fail, lock_lost;
  logic [3:0] retry;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  ccc_pll_lock_sequencer #(
    .PWRDN_CYCLES(16),
    .LOCK_TIMEOUT(4096),
    .LOCK_STABLE (256),
    .RST_DELAY   (16),
    .MAX_RETRIES (3)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (enable),
    .restart_i        (restart),
    .pll_lock_i       (pll_lock),
    .pll_powerdown_n_o(pwrdn_n),
    .fab_reset_n_o    (fab_rst_n),
    .ready_o          (ready),
    .fail_o           (fail),
    .lock_lost_o      (lock_lost),
    .retry_cnt_o      (retry),
    .state_o          (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state !== s; i++) step(1);
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; restart = 1'b0; pll_lock = 1'b0;
    step(3);
    chk("rst_state",   {29'd0, state}, 0);
    chk("rst_pwrdn_n", {31'd0, pwrdn_n}, 0);
    chk("rst_fab",     {31'd0, fab_rst_n}, 0);
    chk("rst_ready",   {31'd0, ready}, 0);
    chk("rst_fail",    {31'd0, fail}, 0);
    chk("rst_lostflag",{31'd0, lock_lost}, 0);
    chk("rst_retry",   {28'd0, retry}, 0);
    rst = 1'b0;
    step(2);
    chk("idle_hold", {29'd0, state}, 0);

    // T1: power-up, lock 100 cycles after POWERDOWN_N rises.
    enable = 1'b1;
    step(1);
    chk("t1_pwrdn",    {29'd0, state}, 1);
    chk("t1_pd_low",   {31'd0, pwrdn_n}, 0);
    step(15);
    chk("t1_pwrdn_end",{29'd0, state}, 1);
    step(1);
    chk("t1_wait",     {29'd0, state}, 2);
    chk("t1_pd_high",  {31'd0, pwrdn_n}, 1);
    step(100);
    pll_lock = 1'b1;
    step(2);
    chk("t1_sync_lat", {29'd0, state}, 2);
    step(1);
    chk("t1_stable",   {29'd0, state}, 3);
    step(255);
    chk("t1_stab_end", {29'd0, state}, 3);
    step(1);
    chk("t1_rstdly",   {29'd0, state}, 4);
    chk("t1_rd_fab",   {31'd0, fab_rst_n}, 0);
    step(15);
    chk("t1_rd_end",   {29'd0, state}, 4);
    step(1);
    chk("t1_run",      {29'd0, state}, 5);
    chk("t1_ready",    {31'd0, ready}, 1);
    chk("t1_fab",      {31'd0, fab_rst_n}, 1);
    chk("t1_retry",    {28'd0, retry}, 0);

    // T4: lock loss in RUN.
    pll_lock = 1'b0;
    step(2);
    chk("t4_ready_2",  {31'd0, ready}, 1);
    step(1);
    chk("t4_state",    {29'd0, state}, 1);
    chk("t4_ready",    {31'd0, ready}, 0);
    chk("t4_fab",      {31'd0, fab_rst_n}, 0);
    chk("t4_lost",     {31'd0, lock_lost}, 1);
    chk("t4_pd",       {31'd0, pwrdn_n}, 0);
    chk("t4_retry",    {28'd0, retry}, 0);
    pll_lock = 1'b1;
    step(16);
    chk("t4_wait",     {29'd0, state}, 2);
    step(1);
    chk("t4_stable",   {29'd0, state}, 3);
    wait_state(3'd5, 400, "t4_rerun");
    chk("t4_lost_sticky", {31'd0, lock_lost}, 1);
    chk("t4_ready_again", {31'd0, ready}, 1);

    // T3: RESTART, then one-cycle glitch at STABLE count 200.
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("t3_restart",  {29'd0, state}, 1);
    chk("t3_lost_clr", {31'd0, lock_lost}, 0);
    step(16);
    chk("t3_wait",     {29'd0, state}, 2);
    step(1);
    chk("t3_stable",   {29'd0, state}, 3);
    step(200);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    chk("t3_glitch_lat", {29'd0, state}, 3);
    step(1);
    chk("t3_back_wait",  {29'd0, state}, 2);
    step(1);
    chk("t3_restable",   {29'd0, state}, 3);
    step(255);
    chk("t3_full_win",   {29'd0, state}, 3);
    step(1);
    chk("t3_rstdly",     {29'd0, state}, 4);
    step(16);
    chk("t3_run",        {29'd0, state}, 5);

    // T5: lock arrives on the exact timeout cycle.
    restart = 1'b1; pll_lock = 1'b0;
    step(1);
    restart = 1'b0;
    step(16);
    chk("t5_wait",     {29'd0, state}, 2);
    step(4093);
    pll_lock = 1'b1;
    step(2);
    chk("t5_last_cyc", {29'd0, state}, 2);
    step(1);
    chk("t5_stable",   {29'd0, state}, 3);
    chk("t5_no_retry", {28'd0, retry}, 0);
    enable = 1'b0; restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("t5_idle",     {29'd0, state}, 0);
    chk("t5_idle_pd",  {31'd0, pwrdn_n}, 0);

    // T2: lock never arrives -> three retries then FAIL.
    pll_lock = 1'b0; enable = 1'b1;
    step(1);
    chk("t2_pwrdn",    {29'd0, state}, 1);
    step(16);
    step(4095);
    chk("t2_to1_pre",  {29'd0, state}, 2);
    step(1);
    chk("t2_to1",      {29'd0, state}, 1);
    chk("t2_retry1",   {28'd0, retry}, 1);
    step(16 + 4096);
    chk("t2_retry2",   {28'd0, retry}, 2);
    step(16 + 4096);
    chk("t2_retry3",   {28'd0, retry}, 3);
    chk("t2_to3_st",   {29'd0, state}, 1);
    step(16 + 4096);
    chk("t2_fail_st",  {29'd0, state}, 6);
    chk("t2_fail",     {31'd0, fail}, 1);
    chk("t2_fail_pd",  {31'd0, pwrdn_n}, 0);
    chk("t2_fail_rty", {28'd0, retry}, 3);
    step(10);
    chk("t2_fail_hold",{29'd0, state}, 6);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("t2_restart",  {29'd0, state}, 1);
    chk("t2_rty_clr",  {28'd0, retry}, 0);
    chk("t2_fail_clr", {31'd0, fail}, 0);

    // T6: asynchronous reset while in RST_DLY.
    pll_lock = 1'b1;
    wait_state(3'd4, 400, "t6_reach_rd");
    step(3);
    chk("t6_pd_before", {31'd0, pwrdn_n}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_st",  {29'd0, state}, 0);
    chk("t6_async_pd",  {31'd0, pwrdn_n}, 0);
    chk("t6_async_fab", {31'd0, fab_rst_n}, 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("t6_restart",   {29'd0, state}, 1);
    wait_state(3'd5, 400, "t6_rerun");
    chk("t6_ready",     {31'd0, ready}, 1);
    chk("t6_lost",      {31'd0, lock_lost}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
